// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration, head-to-tail
// packet locking and credit flow control for each crossbar output port.
module switch_allocator #(
    parameter int VC_NUM     = 2,
    parameter int PORT_NUM   = 6,
    parameter int M_IN       = VC_NUM * PORT_NUM,
    parameter int N_OUT      = PORT_NUM,
    parameter int ROUTE_LEN  = 3,
    parameter int CREDIT_MAX = 4,
    localparam int SEL_W     = $clog2(M_IN),
    localparam int CRED_W    = $clog2(CREDIT_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [M_IN-1:0]           req_valid,
    input  logic [M_IN*ROUTE_LEN-1:0] req_route,
    input  logic [M_IN-1:0]           req_head,
    input  logic [M_IN-1:0]           req_tail,
    input  logic [N_OUT-1:0]          credit_ret,
    output logic [M_IN-1:0]           grant,
    output logic [N_OUT-1:0]          out_valid,
    output logic [N_OUT*SEL_W-1:0]    out_sel,
    output logic [N_OUT-1:0]          out_lock,
    output logic                      credit_err,
    output logic [N_OUT*CRED_W-1:0]   dbg_credit,
    output logic [N_OUT*SEL_W-1:0]    dbg_rr_ptr
);

    // Handshake: a flit moves from slot i exactly in a cycle where req_valid[i] and
    // grant[i] are both high; there is no backpressure memory, requests may drop freely.
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t            state  [N_OUT];
    logic [SEL_W-1:0]  owner  [N_OUT];
    logic [SEL_W-1:0]  rr_ptr [N_OUT];
    logic [CRED_W-1:0] credit [N_OUT];

    logic [M_IN-1:0]   owned;
    logic [N_OUT-1:0]  hit;
    logic [SEL_W-1:0]  pick [N_OUT];

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] x);
        if (int'(x) == M_IN - 1)
            return '0;
        return x + 1'b1;
    endfunction

    // A slot that owns a locked output may not start a packet on any other output.
    always_comb begin
        owned = '0;
        for (int o = 0; o < N_OUT; o++) begin
            if (state[o] == LOCKED)
                owned[owner[o]] = 1'b1;
        end
    end

    always_comb begin
        int               idx;
        logic             found;
        logic [SEL_W-1:0] sel;
        idx   = 0;
        found = 1'b0;
        sel   = '0;
        for (int o = 0; o < N_OUT; o++) begin
            found = 1'b0;
            sel   = '0;
            if (state[o] == LOCKED) begin
                found = req_valid[owner[o]];
                sel   = owner[o];
            end else begin
                for (int k = 0; k < M_IN; k++) begin
                    idx = int'(rr_ptr[o]) + k;
                    if (idx >= M_IN)
                        idx = idx - M_IN;
                    if (!found && req_valid[idx] && req_head[idx] && !owned[idx] &&
                        req_route[idx*ROUTE_LEN +: ROUTE_LEN] == ROUTE_LEN'(o + 1)) begin
                        found = 1'b1;
                        sel   = SEL_W'(idx);
                    end
                end
            end
            hit[o]  = found;
            pick[o] = sel;
        end
    end

    always_comb begin
        grant      = '0;
        out_valid  = '0;
        out_sel    = '0;
        out_lock   = '0;
        dbg_credit = '0;
        dbg_rr_ptr = '0;
        for (int o = 0; o < N_OUT; o++) begin
            out_valid[o] = hit[o] && (credit[o] != '0);
            if (out_valid[o]) begin
                out_sel[o*SEL_W +: SEL_W] = pick[o];
                grant[pick[o]]            = 1'b1;
            end
            out_lock[o]                  = (state[o] == LOCKED);
            dbg_credit[o*CRED_W +: CRED_W] = credit[o];
            dbg_rr_ptr[o*SEL_W +: SEL_W]   = rr_ptr[o];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_err <= 1'b0;
            for (int o = 0; o < N_OUT; o++) begin
                state[o]  <= IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= '0;
                credit[o] <= CRED_W'(CREDIT_MAX);
            end
        end else begin
            for (int o = 0; o < N_OUT; o++) begin
                // Simultaneous consume and return cancel out.
                if (out_valid[o] && !credit_ret[o]) begin
                    credit[o] <= credit[o] - 1'b1;
                end else if (!out_valid[o] && credit_ret[o]) begin
                    if (credit[o] == CRED_W'(CREDIT_MAX))
                        credit_err <= 1'b1;
                    else
                        credit[o] <= credit[o] + 1'b1;
                end

                if (out_valid[o]) begin
                    if (state[o] == IDLE) begin
                        rr_ptr[o] <= wrap_inc(pick[o]);
                        if (!req_tail[pick[o]]) begin
                            state[o] <= LOCKED;
                            owner[o] <= pick[o];
                        end
                    end else if (req_tail[pick[o]]) begin
                        state[o]  <= IDLE;
                        rr_ptr[o] <= wrap_inc(owner[o]);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: a vector table for arbitration, locking and
// credit exhaustion, plus hand sequences for reset, credit accounting and async reset.
module tb_switch_allocator;

    localparam int M  = 12;
    localparam int N  = 6;
    localparam int SW = 4;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [M-1:0]    req_valid;
    logic [M*3-1:0]  req_route;
    logic [M-1:0]    req_head;
    logic [M-1:0]    req_tail;
    logic [N-1:0]    credit_ret;
    logic [M-1:0]    grant;
    logic [N-1:0]    out_valid;
    logic [N*SW-1:0] out_sel;
    logic [N-1:0]    out_lock;
    logic            credit_err;
    logic [N*CW-1:0] dbg_credit;
    logic [N*SW-1:0] dbg_rr_ptr;

    always #5 clk = ~clk;

    switch_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_route  (req_route),
        .req_head   (req_head),
        .req_tail   (req_tail),
        .credit_ret (credit_ret),
        .grant      (grant),
        .out_valid  (out_valid),
        .out_sel    (out_sel),
        .out_lock   (out_lock),
        .credit_err (credit_err),
        .dbg_credit (dbg_credit),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    typedef struct {
        logic [M-1:0]   valid;
        logic [M-1:0]   head;
        logic [M-1:0]   tail;
        logic [M*3-1:0] route;
        logic [N-1:0]   cret;
        logic [M-1:0]   exp_grant;
        logic [N-1:0]   exp_ovalid;
        logic [N-1:0]   exp_lock;
    } vec_t;

    vec_t tbl [17];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [M*3-1:0] route_all(input logic [2:0] code);
        logic [M*3-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) r[i*3 +: 3] = code;
        return r;
    endfunction

    function automatic vec_t mk(input logic [M-1:0] v, input logic [M-1:0] h,
                                input logic [M-1:0] t, input logic [2:0] code,
                                input logic [N-1:0] c, input logic [M-1:0] eg,
                                input logic [N-1:0] eov, input logic [N-1:0] el);
        vec_t r;
        r.valid = v; r.head = h; r.tail = t; r.route = route_all(code); r.cret = c;
        r.exp_grant = eg; r.exp_ovalid = eov; r.exp_lock = el;
        return r;
    endfunction

    task automatic drive(input logic [M-1:0] v, input logic [M-1:0] h, input logic [M-1:0] t,
                         input logic [M*3-1:0] r, input logic [N-1:0] c);
        req_valid  = v;
        req_head   = h;
        req_tail   = t;
        req_route  = r;
        credit_ret = c;
    endtask

    task automatic idle();
        drive('0, '0, '0, '0, '0);
    endtask

    function automatic logic [CW-1:0] cred(input int o);
        return dbg_credit[o*CW +: CW];
    endfunction

    function automatic logic [SW-1:0] rrp(input int o);
        return dbg_rr_ptr[o*SW +: SW];
    endfunction

    initial begin
        // Replenish output 0 after the single-flit test.
        tbl[0]  = mk(12'h000, 12'h000, 12'h000, 3'd0, 6'h01, 12'h000, 6'h00, 6'h00);
        // Round-robin over slots 2, 5, 9 on output 1 with credits returned every cycle.
        tbl[1]  = mk(12'h224, 12'h224, 12'h224, 3'd2, 6'h02, 12'h004, 6'h02, 6'h00);
        tbl[2]  = mk(12'h224, 12'h224, 12'h224, 3'd2, 6'h02, 12'h020, 6'h02, 6'h00);
        tbl[3]  = mk(12'h224, 12'h224, 12'h224, 3'd2, 6'h02, 12'h200, 6'h02, 6'h00);
        tbl[4]  = mk(12'h224, 12'h224, 12'h224, 3'd2, 6'h02, 12'h004, 6'h02, 6'h00);
        // Route 0, route 7 and a non-head flit from a non-owner: nothing granted.
        tbl[5]  = mk(12'h940, 12'h140, 12'h940, 3'd1, 6'h00, 12'h000, 6'h00, 6'h00);
        tbl[5].route[6*3 +: 3] = 3'd0;
        tbl[5].route[8*3 +: 3] = 3'd7;
        // Output 3: slot 5 moves rr_ptr to 6, then slot 7 locks for 3 flits ahead of slot 1.
        tbl[6]  = mk(12'h020, 12'h020, 12'h020, 3'd4, 6'h08, 12'h020, 6'h08, 6'h00);
        tbl[7]  = mk(12'h082, 12'h082, 12'h002, 3'd4, 6'h08, 12'h080, 6'h08, 6'h00);
        tbl[8]  = mk(12'h082, 12'h002, 12'h002, 3'd4, 6'h08, 12'h080, 6'h08, 6'h08);
        tbl[9]  = mk(12'h082, 12'h002, 12'h082, 3'd4, 6'h08, 12'h080, 6'h08, 6'h08);
        tbl[10] = mk(12'h002, 12'h002, 12'h002, 3'd4, 6'h08, 12'h002, 6'h08, 6'h00);
        // Output 0 credit exhaustion: 4 grants, 5th denied until one credit returns.
        tbl[11] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h00, 12'h001, 6'h01, 6'h00);
        tbl[12] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h00, 12'h001, 6'h01, 6'h00);
        tbl[13] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h00, 12'h001, 6'h01, 6'h00);
        tbl[14] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h00, 12'h001, 6'h01, 6'h00);
        tbl[15] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h01, 12'h000, 6'h00, 6'h00);
        tbl[16] = mk(12'h001, 12'h001, 12'h001, 3'd1, 6'h00, 12'h001, 6'h01, 6'h00);

        // Reset state
        rst = 1'b0;
        idle();
        @(negedge clk); #2;
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_ovalid", 64'(out_valid), 64'h0);
        check("rst_sel", 64'(out_sel), 64'h0);
        check("rst_lock", 64'(out_lock), 64'h0);
        check("rst_err", 64'(credit_err), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        for (int o = 0; o < N; o++) begin
            check($sformatf("rst_credit%0d", o), 64'(cred(o)), 64'd4);
            check($sformatf("rst_rr%0d", o), 64'(rrp(o)), 64'd0);
        end

        // Single-flit packet from slot 3 to XPOS, granted in the same cycle.
        @(negedge clk);
        drive(12'h008, 12'h008, 12'h008, route_all(3'd1), 6'h00);
        #2;
        check("t1_grant", 64'(grant), 64'h008);
        check("t1_ovalid", 64'(out_valid), 64'h01);
        check("t1_sel0", 64'(out_sel[0 +: SW]), 64'd3);
        @(negedge clk);
        idle();
        #2;
        check("t1_credit0", 64'(cred(0)), 64'd3);
        check("t1_rr0", 64'(rrp(0)), 64'd4);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i].valid, tbl[i].head, tbl[i].tail, tbl[i].route, tbl[i].cret);
            #2;
            check($sformatf("row%0d_grant", i), 64'(grant), 64'(tbl[i].exp_grant));
            check($sformatf("row%0d_ovalid", i), 64'(out_valid), 64'(tbl[i].exp_ovalid));
            check($sformatf("row%0d_lock", i), 64'(out_lock), 64'(tbl[i].exp_lock));
        end
        @(negedge clk);
        idle();
        #2;
        check("tbl_credit0", 64'(cred(0)), 64'd0);
        check("tbl_credit3", 64'(cred(3)), 64'd4);
        check("tbl_rr0", 64'(rrp(0)), 64'd1);
        check("tbl_rr1", 64'(rrp(1)), 64'd3);
        check("tbl_rr3", 64'(rrp(3)), 64'd2);
        check("tbl_err", 64'(credit_err), 64'h0);

        // Output 2: bring credit to 2, then consume and return together.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(12'h010, 12'h010, 12'h010, route_all(3'd3), (i == 2) ? 6'h04 : 6'h00);
            #2;
            check($sformatf("t5_grant%0d", i), 64'(grant), 64'h010);
        end
        @(negedge clk);
        idle();
        #2;
        check("t5_credit_same", 64'(cred(2)), 64'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive('0, '0, '0, '0, 6'h04);
        end
        @(negedge clk);
        idle();
        #2;
        check("t5_credit_full", 64'(cred(2)), 64'd4);
        check("t5_err_clear", 64'(credit_err), 64'h0);
        @(negedge clk);
        drive('0, '0, '0, '0, 6'h04);
        @(negedge clk);
        idle();
        #2;
        check("t5_err_set", 64'(credit_err), 64'h1);
        check("t5_credit_sat", 64'(cred(2)), 64'd4);

        // Async reset mid-packet on output 5.
        @(negedge clk);
        drive(12'h400, 12'h400, 12'h000, route_all(3'd6), 6'h00);
        #2;
        check("t6_head_grant", 64'(grant), 64'h400);
        check("t6_head_lock", 64'(out_lock), 64'h00);
        @(negedge clk);
        drive(12'h400, 12'h000, 12'h000, route_all(3'd6), 6'h00);
        #2;
        check("t6_body_grant", 64'(grant), 64'h400);
        check("t6_body_lock", 64'(out_lock), 64'h20);
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_lock", 64'(out_lock), 64'h00);
        check("t6_async_grant", 64'(grant), 64'h000);
        check("t6_async_ovalid", 64'(out_valid), 64'h00);
        check("t6_async_err", 64'(credit_err), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("t6_rel_grant", 64'(grant), 64'h000);
        check("t6_rel_credit5", 64'(cred(5)), 64'd4);
        @(negedge clk);
        #2;
        check("t6_rel_grant2", 64'(grant), 64'h000);
        check("t6_rel_lock", 64'(out_lock), 64'h00);

        @(negedge clk);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
